axi_rd_burst_responder: RTL and testbench

// AXI4 read-side subordinate answering the refill bursts issued by the L1I$ AXI shim.

---
 rtl/axi_rd_burst_responder_pkg.sv | 81 ++++++++
 rtl/fifo_v3.sv | 56 +++++
 rtl/axi_rd_burst_responder.sv | 166 ++++++++++++++++
 tb/tb_axi_rd_burst_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_burst_responder_pkg.sv
// AXI bus types, burst/resp encodings and the beat address helper shared by the
// read burst responder and its bench.
package axi_rd_burst_responder_pkg;

  localparam int unsigned AxiAddrW = 64;
  localparam int unsigned AxiDataW = 64;
  localparam int unsigned AxiIdW   = 4;

  typedef logic [1:0] axi_burst_t;
  typedef logic [1:0] axi_resp_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [7:0] axi_len_t;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;
  localparam axi_resp_t  RESP_OKAY   = 2'b00;
  localparam axi_resp_t  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    axi_len_t            len;
    axi_size_t           size;
    axi_burst_t          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiIdW-1:0] id;
    axi_resp_t         resp;
  } axi_b_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    axi_resp_t           resp;
    logic                last;
  } axi_r_t;

  typedef struct packed {
    logic    aw_valid;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_rsp_t;

  // Beat 0 keeps the unaligned start address; later INCR beats step from the size-aligned base.
  function automatic logic [AxiAddrW-1:0] beat_addr(input logic [AxiAddrW-1:0] addr,
                                                    input axi_size_t           size,
                                                    input axi_burst_t          burst,
                                                    input logic [8:0]          beat);
    logic [AxiAddrW-1:0] step;
    logic [AxiAddrW-1:0] res;
    step = {{(AxiAddrW-1){1'b0}}, 1'b1} << size;
    if ((burst == BURST_FIXED) || (beat == 9'd0)) begin
      res = addr;
    end else begin
      res = (addr & ~(step - {{(AxiAddrW-1){1'b0}}, 1'b1}))
          + ({{(AxiAddrW-9){1'b0}}, beat} << size);
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Power-of-two synchronous FIFO; flush_i empties it and doubles as its reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DATA_WIDTH   = 64
) (
  input  logic                          clk_i,
  input  logic                          flush_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        usage_o,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          push_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  input  logic                          pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW      = $clog2(DEPTH) + 1;

  logic [AddrDepth-1:0]  rd_ptr_q;
  logic [AddrDepth-1:0]  wr_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;

  assign full_o   = (count_q == CntW'(DEPTH));
  assign bypass_s = FALL_THROUGH & (count_q == '0) & push_i;
  assign empty_o  = (count_q == '0) & ~bypass_s;
  assign usage_o  = count_q;
  assign data_o   = bypass_s ? data_i : mem_q[rd_ptr_q];
  assign pop_s    = pop_i & (count_q != '0);
  // A pop in the same cycle frees a slot, so a push into a full buffer is still safe.
  assign push_s   = push_i & (~full_o | pop_s) & ~(bypass_s & pop_i);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AddrDepth'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AddrDepth'(1);
      end
      count_q <= count_q + CntW'(push_s) - CntW'(pop_s);
    end
  end

endmodule

// File: rtl/axi_rd_burst_responder.sv
// AXI4 read-only subordinate: expands one AR burst at a time into single-word
// SRAM reads and returns the buffered data as R beats.
module axi_rd_burst_responder
  import axi_rd_burst_responder_pkg::*;
#(
  parameter int unsigned AxiAddrWidth = AxiAddrW,
  parameter int unsigned AxiDataWidth = AxiDataW,
  parameter int unsigned AxiIdWidth   = AxiIdW,
  parameter logic [63:0] BaseAddr     = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MemBytes     = 64'h0000_0000_0001_0000,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  axi_req_t                axi_req_i,
  output axi_rsp_t                axi_resp_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [AxiAddrWidth-1:0] mem_addr_o,
  input  logic                    mem_rvalid_i,
  input  logic [AxiDataWidth-1:0] mem_rdata_i
);

  localparam int unsigned BeatBytesLog = $clog2(AxiDataWidth / 8);
  localparam int unsigned CntW         = $clog2(FifoDepth) + 1;
  localparam logic [CntW-1:0]         DepthCnt  = CntW'(FifoDepth);
  localparam logic [AxiAddrWidth-1:0] LimitAddr = AxiAddrWidth'(BaseAddr + MemBytes);
  localparam logic [AxiAddrWidth-1:0] BeatMask  =
    {{(AxiAddrWidth-BeatBytesLog){1'b1}}, {BeatBytesLog{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, BURST = 2'd2, ERR = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q;
  axi_len_t                len_q;
  axi_size_t               size_q;
  axi_burst_t              burst_q;
  logic [7:0]              beat_cnt_q;
  logic [8:0]              issue_cnt_q;
  logic [CntW-1:0]         inflight_q, inflight_d;

  logic                    ar_ready_s, ar_fire_s, decode_err_s;
  logic                    mem_req_s, gnt_fire_s, push_s, pop_s;
  logic                    r_valid_s, r_fire_s, r_last_s;
  logic                    fifo_full_s, fifo_empty_s;
  logic [CntW-1:0]         fifo_usage_s;
  logic [AxiDataWidth-1:0] fifo_rdata_s;
  logic                    unused_s;

  assign ar_ready_s   = (state_q == IDLE) & ~rst_i;
  assign ar_fire_s    = axi_req_i.ar_valid & ar_ready_s;
  assign decode_err_s = (addr_q < AxiAddrWidth'(BaseAddr)) | (addr_q >= LimitAddr)
                      | (size_q > 3'(BeatBytesLog)) | (burst_q == BURST_WRAP);
  // Credits cover both buffered beats and reads still in flight, so the FIFO never overflows.
  assign mem_req_s    = (state_q == BURST) & (issue_cnt_q <= {1'b0, len_q})
                      & ((fifo_usage_s + inflight_q) < DepthCnt);
  assign gnt_fire_s   = mem_req_s & mem_gnt_i;
  assign push_s       = (state_q == BURST) & mem_rvalid_i & (inflight_q != '0);
  assign r_valid_s    = (state_q == ERR) | ((state_q == BURST) & ~fifo_empty_s);
  assign r_fire_s     = r_valid_s & axi_req_i.r_ready;
  assign r_last_s     = (beat_cnt_q == len_q);
  assign pop_s        = (state_q == BURST) & r_fire_s;
  assign inflight_d   = inflight_q + CntW'(gnt_fire_s) - CntW'(push_s);

  assign mem_req_o  = mem_req_s;
  assign mem_addr_o = beat_addr(addr_q, size_q, burst_q, issue_cnt_q) & BeatMask;

  assign unused_s = ^{axi_req_i.aw_valid, axi_req_i.w_valid, axi_req_i.b_ready,
                      axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                      axi_req_i.ar.qos, axi_req_i.ar.region, fifo_full_s};

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_fire_s) state_d = CHECK;
        else           state_d = IDLE;
      end
      CHECK: begin
        if (decode_err_s) state_d = ERR;
        else              state_d = BURST;
      end
      BURST, ERR: begin
        if (r_fire_s && r_last_s) state_d = IDLE;
        else                      state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // R channel and handshake outputs decoded from the current state.
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.ar_ready = ar_ready_s;
    axi_resp_o.r_valid  = r_valid_s;
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.last   = r_last_s;
    case (state_q)
      BURST: begin
        axi_resp_o.r.data = fifo_rdata_s;
        axi_resp_o.r.resp = RESP_OKAY;
      end
      ERR: begin
        axi_resp_o.r.data = '0;
        axi_resp_o.r.resp = RESP_SLVERR;
      end
      default: axi_resp_o.r.resp = RESP_OKAY;
    endcase
  end

  // Latched AR fields and the issue/return/in-flight counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BURST_FIXED;
      beat_cnt_q  <= 8'd0;
      issue_cnt_q <= 9'd0;
      inflight_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (ar_fire_s) begin
        id_q        <= axi_req_i.ar.id;
        addr_q      <= axi_req_i.ar.addr;
        len_q       <= axi_req_i.ar.len;
        size_q      <= axi_req_i.ar.size;
        burst_q     <= axi_req_i.ar.burst;
        beat_cnt_q  <= 8'd0;
        issue_cnt_q <= 9'd0;
      end else begin
        if (gnt_fire_s) issue_cnt_q <= issue_cnt_q + 9'd1;
        if (r_fire_s)   beat_cnt_q  <= beat_cnt_q + 8'd1;
      end
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (FifoDepth),
    .DATA_WIDTH   (AxiDataWidth)
  ) i_rdata_fifo (
    .clk_i   (clk_i),
    .flush_i (rst_i),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .usage_o (fifo_usage_s),
    .data_i  (mem_rdata_i),
    .push_i  (push_s),
    .data_o  (fifo_rdata_s),
    .pop_i   (pop_s)
  );

endmodule

// File: tb/tb_axi_rd_burst_responder.sv
// Directed bench for axi_rd_burst_responder with a 1-cycle-latency memory model.
module tb_axi_rd_burst_responder;
  import axi_rd_burst_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  axi_req_t    axi_req;
  axi_rsp_t    axi_resp;
  logic        mem_req;
  logic        mem_gnt;
  logic [63:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata  = 64'd0;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int grant_cnt = 0;
  logic [63:0] grant_addr [0:127];
  int          grant_cyc  [0:127];

  logic [63:0] rx_data [0:15];
  logic [3:0]  rx_id   [0:15];
  logic [1:0]  rx_resp [0:15];
  logic        rx_last [0:15];
  int          rx_cyc  [0:15];
  int          rx_n;

  axi_rd_burst_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .axi_req_i    (axi_req),
    .axi_resp_o   (axi_resp),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_addr_o   (mem_addr),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0010) return 64'h0000_0000_DEAD_BEEF;
    return {a[31:0] ^ 32'h1234_5678, a[31:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    mem_rvalid <= mem_req && mem_gnt;
    mem_rdata  <= mem_model(mem_addr);
    if (mem_req && mem_gnt) begin
      if (grant_cnt < 128) begin
        grant_addr[grant_cnt] <= mem_addr;
        grant_cyc[grant_cnt]  <= cyc;
      end
      grant_cnt <= grant_cnt + 1;
    end
  end

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int hs_cyc);
    int t;
    t = 0;
    @(negedge clk);
    axi_req.ar.id    = id;
    axi_req.ar.addr  = addr;
    axi_req.ar.len   = len;
    axi_req.ar.size  = size;
    axi_req.ar.burst = burst;
    axi_req.ar_valid = 1'b1;
    while (axi_resp.ar_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    hs_cyc = cyc;
    checks++;
    if (t >= 50) $display("FAIL ar_accept: ar_ready low for %0d cycles, required 1", t);
    else passes++;
    @(negedge clk);
    axi_req.ar_valid = 1'b0;
  endtask

  task automatic recv(input int nbeats, input int budget);
    int t;
    t = 0;
    rx_n = 0;
    axi_req.r_ready = 1'b1;
    while (rx_n < nbeats && t < budget) begin
      if (axi_resp.r_valid === 1'b1) begin
        rx_data[rx_n] = axi_resp.r.data;
        rx_id[rx_n]   = axi_resp.r.id;
        rx_resp[rx_n] = axi_resp.r.resp;
        rx_last[rx_n] = axi_resp.r.last;
        rx_cyc[rx_n]  = cyc;
        rx_n++;
      end
      @(negedge clk);
      t++;
    end
    checks++;
    if (rx_n != nbeats) $display("FAIL beat_count: got %0d beats, required %0d", rx_n, nbeats);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi_resp.ar_ready, axi_resp.r_valid, mem_req} !== 3'b000)
      $display("FAIL reset_outputs: ar_ready/r_valid/mem_req=%b, required 000",
               {axi_resp.ar_ready, axi_resp.r_valid, mem_req});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (axi_resp.ar_ready !== 1'b1) $display("FAIL reset_ar_ready: got %b, required 1", axi_resp.ar_ready);
    else passes++;
    checks++;
    if ({axi_resp.aw_ready, axi_resp.w_ready, axi_resp.b_valid} !== 3'b000)
      $display("FAIL write_channel: aw_ready/w_ready/b_valid=%b, required 000",
               {axi_resp.aw_ready, axi_resp.w_ready, axi_resp.b_valid});
    else passes++;
  endtask

  task automatic test_single_beat();
    int n;
    int g0;
    g0 = grant_cnt;
    send_ar(4'd5, 64'h8000_0010, 8'd0, 3'd3, BURST_INCR, n);
    recv(1, 20);
    checks++;
    if (grant_cnt - g0 != 1 || grant_addr[g0] !== 64'h8000_0010 || grant_cyc[g0] != n + 2)
      $display("FAIL single_mem: grants=%0d addr=%h cyc=%0d, required 1 80000010 %0d",
               grant_cnt - g0, grant_addr[g0], grant_cyc[g0], n + 2);
    else passes++;
    checks++;
    if (rx_data[0] !== 64'hDEAD_BEEF || rx_id[0] !== 4'd5 || rx_last[0] !== 1'b1 || rx_resp[0] !== RESP_OKAY)
      $display("FAIL single_beat: data=%h id=%0d last=%b resp=%0d, required deadbeef 5 1 0",
               rx_data[0], rx_id[0], rx_last[0], rx_resp[0]);
    else passes++;
    checks++;
    if (rx_cyc[0] != n + 4) $display("FAIL single_latency: r_valid at N+%0d, required N+4", rx_cyc[0] - n);
    else passes++;
  endtask

  task automatic test_line_refill();
    int n;
    int g0;
    g0 = grant_cnt;
    send_ar(4'd2, 64'h8000_0100, 8'd1, 3'd3, BURST_INCR, n);
    recv(2, 20);
    checks++;
    if (grant_cnt - g0 != 2 || grant_addr[g0] !== 64'h8000_0100 || grant_addr[g0+1] !== 64'h8000_0108)
      $display("FAIL refill_addr: grants=%0d a0=%h a1=%h, required 2 80000100 80000108",
               grant_cnt - g0, grant_addr[g0], grant_addr[g0+1]);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_data[i] !== mem_model(64'h8000_0100 + 64'(8*i)) || rx_last[i] !== (i == 1) || rx_id[i] !== 4'd2)
        $display("FAIL refill_beat%0d: data=%h last=%b id=%0d, required %h %b 2", i, rx_data[i],
                 rx_last[i], rx_id[i], mem_model(64'h8000_0100 + 64'(8*i)), (i == 1));
      else passes++;
    end
    checks++;
    if (rx_cyc[1] != rx_cyc[0] + 1) $display("FAIL refill_b2b: beat gap %0d, required 1", rx_cyc[1] - rx_cyc[0]);
    else passes++;
  endtask

  task automatic test_backpressure();
    int n;
    int g0;
    logic seen;
    logic stable;
    logic [63:0] d0;
    g0 = grant_cnt;
    seen = 1'b0;
    stable = 1'b1;
    d0 = 64'd0;
    axi_req.r_ready = 1'b0;
    send_ar(4'd7, 64'h8000_0200, 8'd7, 3'd3, BURST_INCR, n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_resp.r_valid === 1'b1) begin
        if (!seen) begin
          seen = 1'b1;
          d0 = axi_resp.r.data;
        end else if (axi_resp.r.data !== d0 || axi_resp.r.last !== 1'b0) begin
          stable = 1'b0;
        end
      end else if (seen) begin
        stable = 1'b0;
      end
    end
    checks++;
    if (grant_cnt - g0 != 4) $display("FAIL bp_grants: %0d grants while stalled, required 4", grant_cnt - g0);
    else passes++;
    checks++;
    if (!seen || !stable || d0 !== mem_model(64'h8000_0200))
      $display("FAIL bp_hold: seen=%b stable=%b data=%h, required 1 1 %h", seen, stable, d0,
               mem_model(64'h8000_0200));
    else passes++;
    recv(8, 40);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_data[i] !== mem_model(64'h8000_0200 + 64'(8*i)) || rx_last[i] !== (i == 7) || rx_resp[i] !== RESP_OKAY)
        $display("FAIL bp_beat%0d: data=%h last=%b resp=%0d, required %h %b 0", i, rx_data[i], rx_last[i],
                 rx_resp[i], mem_model(64'h8000_0200 + 64'(8*i)), (i == 7));
      else passes++;
    end
    checks++;
    if (grant_cnt - g0 != 8 || grant_addr[g0+7] !== 64'h8000_0238)
      $display("FAIL bp_total: grants=%0d last_addr=%h, required 8 80000238", grant_cnt - g0, grant_addr[g0+7]);
    else passes++;
  endtask

  task automatic test_decode_err();
    int n;
    int g0;
    g0 = grant_cnt;
    send_ar(4'd9, 64'h0000_1000, 8'd3, 3'd3, BURST_INCR, n);
    recv(4, 20);
    checks++;
    if (grant_cnt != g0) $display("FAIL decerr_mem: %0d memory grants, required 0", grant_cnt - g0);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_resp[i] !== RESP_SLVERR || rx_data[i] !== 64'd0 || rx_last[i] !== (i == 3) || rx_id[i] !== 4'd9)
        $display("FAIL decerr_beat%0d: resp=%0d data=%h last=%b id=%0d, required 2 0 %b 9", i, rx_resp[i],
                 rx_data[i], rx_last[i], rx_id[i], (i == 3));
      else passes++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    send_ar(4'd1, 64'h8000_0300, 8'd7, 3'd3, BURST_INCR, n);
    recv(3, 20);
    rst = 1'b1;
    axi_req.r_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (axi_resp.r_valid !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL midrst_outputs: r_valid=%b mem_req=%b, required 0 0", axi_resp.r_valid, mem_req);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (axi_resp.ar_ready !== 1'b1 || axi_resp.r_valid !== 1'b0)
      $display("FAIL midrst_idle: ar_ready=%b r_valid=%b, required 1 0", axi_resp.ar_ready, axi_resp.r_valid);
    else passes++;
    send_ar(4'd3, 64'h8000_0400, 8'd1, 3'd3, BURST_INCR, n);
    recv(2, 20);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_data[i] !== mem_model(64'h8000_0400 + 64'(8*i)) || rx_last[i] !== (i == 1) || rx_id[i] !== 4'd3)
        $display("FAIL midrst_beat%0d: data=%h last=%b id=%0d, required %h %b 3", i, rx_data[i], rx_last[i],
                 rx_id[i], mem_model(64'h8000_0400 + 64'(8*i)), (i == 1));
      else passes++;
    end
  endtask

  task automatic test_fixed_burst();
    int n;
    int g0;
    g0 = grant_cnt;
    send_ar(4'd4, 64'h8000_0020, 8'd3, 3'd3, BURST_FIXED, n);
    recv(4, 20);
    checks++;
    if (grant_cnt - g0 != 4) $display("FAIL fixed_grants: %0d grants, required 4", grant_cnt - g0);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_addr[g0+i] !== 64'h8000_0020 || rx_data[i] !== mem_model(64'h8000_0020) || rx_last[i] !== (i == 3))
        $display("FAIL fixed_beat%0d: addr=%h data=%h last=%b, required 80000020 %h %b", i, grant_addr[g0+i],
                 rx_data[i], rx_last[i], mem_model(64'h8000_0020), (i == 3));
      else passes++;
    end
  endtask

  task automatic test_wrap_burst();
    int n;
    int g0;
    g0 = grant_cnt;
    send_ar(4'd6, 64'h8000_0040, 8'd1, 3'd3, BURST_WRAP, n);
    recv(2, 20);
    checks++;
    if (grant_cnt != g0 || rx_resp[0] !== RESP_SLVERR || rx_resp[1] !== RESP_SLVERR || rx_last[1] !== 1'b1)
      $display("FAIL wrap_err: grants=%0d resp0=%0d resp1=%0d last1=%b, required 0 2 2 1", grant_cnt - g0,
               rx_resp[0], rx_resp[1], rx_last[1]);
    else passes++;
  endtask

  task automatic test_boundaries();
    logic [63:0] b_addr [0:3];
    logic [2:0]  b_size [0:3];
    logic [1:0]  b_resp [0:3];
    int n;
    int g0;
    b_addr[0] = 64'h8000_FFF8; b_size[0] = 3'd3; b_resp[0] = RESP_OKAY;
    b_addr[1] = 64'h8001_0000; b_size[1] = 3'd3; b_resp[1] = RESP_SLVERR;
    b_addr[2] = 64'h7FFF_FFF8; b_size[2] = 3'd3; b_resp[2] = RESP_SLVERR;
    b_addr[3] = 64'h8000_0000; b_size[3] = 3'd4; b_resp[3] = RESP_SLVERR;
    for (int k = 0; k < 4; k++) begin
      g0 = grant_cnt;
      send_ar(4'd8, b_addr[k], 8'd0, b_size[k], BURST_INCR, n);
      recv(1, 20);
      checks++;
      if (rx_resp[0] !== b_resp[k] || (grant_cnt - g0) != ((b_resp[k] == RESP_OKAY) ? 1 : 0))
        $display("FAIL bound%0d: resp=%0d grants=%0d, required %0d %0d", k, rx_resp[0], grant_cnt - g0,
                 b_resp[k], (b_resp[k] == RESP_OKAY) ? 1 : 0);
      else passes++;
    end
  endtask

  initial begin
    rst = 1'b1;
    axi_req = '0;
    mem_gnt = 1'b1;
    test_reset();
    test_single_beat();
    test_line_refill();
    test_backpressure();
    test_decode_err();
    test_reset_mid_burst();
    test_fixed_burst();
    test_wrap_burst();
    test_boundaries();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
